// File: rtl/uart_buffered.sv
// Buffered UART: 16x oversampled RX/TX with configurable frame format and FWFT RX FIFO.
// All bit timing derives from a shared enable16 tick of freq_hz/baud/16 clocks.
module uart_buffered #(
  parameter int freq_hz    = 100000000,
  parameter int baud       = 38400,
  parameter int data_bits  = 8,
  parameter int parity     = 0,
  parameter int stop_bits  = 1,
  parameter int fifo_depth = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          uart_rxd,
  output logic                          uart_txd,
  output logic [data_bits-1:0]          rx_data,
  output logic                          rx_avail,
  input  logic                          rx_ack,
  output logic [$clog2(fifo_depth):0]   rx_level,
  input  logic [data_bits-1:0]          tx_data,
  input  logic                          tx_wr,
  output logic                          tx_full,
  output logic [$clog2(fifo_depth):0]   tx_level,
  output logic                          tx_busy,
  output logic [2:0]                    err_flags,
  input  logic                          err_clr
);
  localparam int A   = $clog2(fifo_depth);
  localparam int L   = A + 1;
  localparam int DIV = freq_hz / baud / 16;
  localparam int CW  = $clog2(DIV + 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;

  function automatic logic par_bit(input logic [data_bits-1:0] w);
    return (parity == 1) ? ~^w : ^w;
  endfunction

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          rxd_meta, rxd_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= CW'(DIV - 1);
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      div_cnt  <= (div_cnt == '0) ? CW'(DIV - 1) : div_cnt - 1'b1;
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
    end
  end
  assign tick = (div_cnt == '0);

  // ---------------- RX FSM ----------------
  rx_state_t             rx_state_reg, rx_state_next;
  logic [3:0]            rx_tcnt_reg, rx_tcnt_next;
  logic [2:0]            rx_bit_reg, rx_bit_next;
  logic [data_bits-1:0]  rx_shift_reg, rx_shift_next;
  logic                  rx_pbad_reg, rx_pbad_next;
  logic                  rx_push_reg, rx_push_next;
  logic                  frame_ev, parity_ev, overrun_ev;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_tcnt_next  = rx_tcnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_pbad_next  = rx_pbad_reg;
    rx_push_next  = 1'b0;
    frame_ev      = 1'b0;
    parity_ev     = 1'b0;
    case (rx_state_reg)
      R_IDLE: if (tick && !rxd_s) begin
        rx_state_next = R_START;
        rx_tcnt_next  = 4'd0;
      end
      R_START: if (tick) begin
        if (rx_tcnt_reg == 4'd7) begin
          if (rxd_s) rx_state_next = R_IDLE;
          else begin
            rx_state_next = R_DATA;
            rx_tcnt_next  = 4'd0;
            rx_bit_next   = 3'd0;
            rx_pbad_next  = 1'b0;
          end
        end else rx_tcnt_next = rx_tcnt_reg + 4'd1;
      end
      R_DATA: if (tick) begin
        if (rx_tcnt_reg == 4'd15) begin
          rx_tcnt_next  = 4'd0;
          rx_shift_next = {rxd_s, rx_shift_reg[data_bits-1:1]};
          if (rx_bit_reg == 3'(data_bits - 1)) rx_state_next = (parity != 0) ? R_PAR : R_STOP;
          else rx_bit_next = rx_bit_reg + 3'd1;
        end else rx_tcnt_next = rx_tcnt_reg + 4'd1;
      end
      R_PAR: if (tick) begin
        if (rx_tcnt_reg == 4'd15) begin
          rx_tcnt_next  = 4'd0;
          rx_pbad_next  = (rxd_s != par_bit(rx_shift_reg));
          rx_state_next = R_STOP;
        end else rx_tcnt_next = rx_tcnt_reg + 4'd1;
      end
      R_STOP: if (tick) begin
        if (rx_tcnt_reg == 4'd15) begin
          if (!rxd_s) begin
            frame_ev      = 1'b1;
            rx_state_next = R_BRK;
          end else begin
            parity_ev     = rx_pbad_reg;
            rx_push_next  = !rx_pbad_reg;
            rx_state_next = R_IDLE;
          end
        end else rx_tcnt_next = rx_tcnt_reg + 4'd1;
      end
      R_BRK: if (rxd_s) rx_state_next = R_IDLE;
      default: rx_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_reg <= R_IDLE;
      rx_tcnt_reg  <= 4'd0;
      rx_bit_reg   <= 3'd0;
      rx_shift_reg <= '0;
      rx_pbad_reg  <= 1'b0;
      rx_push_reg  <= 1'b0;
      err_flags    <= 3'b000;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_tcnt_reg  <= rx_tcnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_pbad_reg  <= rx_pbad_next;
      rx_push_reg  <= rx_push_next;
      err_flags    <= (err_clr ? 3'b000 : err_flags) | {overrun_ev, parity_ev, frame_ev};
    end
  end

  // ---------------- RX FIFO ----------------
  logic [data_bits-1:0] rx_mem [fifo_depth];
  logic [A-1:0]         rx_wp, rx_rp;
  logic [L-1:0]         rx_cnt;
  logic                 rx_pop, rx_wr, rx_full;

  assign rx_full    = (rx_cnt == L'(fifo_depth));
  assign rx_avail   = (rx_cnt != '0);
  assign rx_pop     = rx_ack && rx_avail;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign rx_wr      = rx_push_reg && (!rx_full || rx_pop);
  assign overrun_ev = rx_push_reg && rx_full && !rx_pop;
  assign rx_data    = rx_avail ? rx_mem[rx_rp] : '0;
  assign rx_level   = rx_cnt;

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wp] <= rx_shift_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_wr)  rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      case ({rx_wr, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- TX FIFO ----------------
  logic [data_bits-1:0] tx_mem [fifo_depth];
  logic [A-1:0]         tx_wp, tx_rp;
  logic [L-1:0]         tx_cnt;
  logic                 tx_push, tx_pop, tx_empty;
  logic [data_bits-1:0] tx_head;

  assign tx_full  = (tx_cnt == L'(fifo_depth));
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = tx_wr && !tx_full;
  assign tx_head  = tx_mem[tx_rp];
  assign tx_level = tx_cnt;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t            tx_state_reg, tx_state_next;
  logic [3:0]           tx_tcnt_reg, tx_tcnt_next;
  logic [2:0]           tx_bit_reg, tx_bit_next;
  logic [data_bits-1:0] tx_shift_reg, tx_shift_next;
  logic                 tx_par_reg, tx_par_next;
  logic                 txd_reg, txd_next;

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_tcnt_next  = tx_tcnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_par_next   = tx_par_reg;
    txd_next      = txd_reg;
    tx_pop        = 1'b0;
    if (tick) begin
      if (tx_state_reg != T_IDLE && tx_tcnt_reg != 4'd15) tx_tcnt_next = tx_tcnt_reg + 4'd1;
      else begin
        tx_tcnt_next = 4'd0;
        case (tx_state_reg)
          T_START: begin
            tx_state_next = T_DATA;
            tx_bit_next   = 3'd0;
            txd_next      = tx_shift_reg[0];
          end
          T_DATA: begin
            if (tx_bit_reg == 3'(data_bits - 1)) begin
              tx_state_next = (parity != 0) ? T_PAR : T_STOP;
              txd_next      = (parity != 0) ? tx_par_reg : 1'b1;
              tx_bit_next   = 3'd0;
            end else begin
              tx_bit_next   = tx_bit_reg + 3'd1;
              tx_shift_next = tx_shift_reg >> 1;
              txd_next      = tx_shift_reg[1];
            end
          end
          T_PAR: begin
            tx_state_next = T_STOP;
            tx_bit_next   = 3'd0;
            txd_next      = 1'b1;
          end
          default: begin
            // IDLE, or the tick closing the last stop bit: start the next word back to back.
            if (tx_state_reg == T_STOP && tx_bit_reg != 3'(stop_bits - 1)) begin
              tx_bit_next = tx_bit_reg + 3'd1;
            end else if (!tx_empty) begin
              tx_pop        = 1'b1;
              tx_shift_next = tx_head;
              tx_par_next   = par_bit(tx_head);
              txd_next      = 1'b0;
              tx_state_next = T_START;
            end else begin
              tx_state_next = T_IDLE;
              txd_next      = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_reg <= T_IDLE;
      tx_tcnt_reg  <= 4'd0;
      tx_bit_reg   <= 3'd0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      txd_reg      <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_tcnt_reg  <= tx_tcnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_par_reg   <= tx_par_next;
      txd_reg      <= txd_next;
    end
  end

  assign uart_txd = txd_reg;
  assign tx_busy  = !tx_empty || (tx_state_reg != T_IDLE);
endmodule
